// File: rtl/stereo_axis_pkg.sv
// stereo_axis_pkg: shared pixel constants and gray-to-RGB helper for the stereo AXIS stages.
package stereo_axis_pkg;
   localparam int GRAY_PIX_W = 8;
   localparam int RGB_PIX_W = 24;
   localparam int PIX_PER_GRAY_BEAT = 4;
   function automatic logic [RGB_PIX_W-1:0] gray8_to_rgb24(input logic [GRAY_PIX_W-1:0] g);
      return {3{g}};
   endfunction
endpackage

// File: rtl/gray_to_rgb_axis_if.sv
// gray_to_rgb_axis_if: AXI4-Stream bundle with tuser/tlast, parameterised data width.
interface gray_to_rgb_axis_if #(parameter int W = 32);
   logic tvalid;
   logic tready;
   logic [W-1:0] tdata;
   logic tuser;
   logic tlast;
   modport master(output tvalid, tdata, tuser, tlast, input tready);
   modport slave(input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/gray_to_rgb_axis.sv
// gray_to_rgb_axis: expands a 4-pixel gray beat into 1, 2 or 4 RGB beats with R=G=B=gray.
module gray_to_rgb_axis
   import stereo_axis_pkg::*;
#(
   parameter int C_S_AXIS_gray_TDATA_WIDTH = 32,
   parameter int C_M_AXIS_rgb_TDATA_WIDTH = 24
) (
   input logic aclk,
   input logic aresetn,
   gray_to_rgb_axis_if.slave s_axis_gray,
   gray_to_rgb_axis_if.master m_axis_rgb
);
   localparam int P = C_M_AXIS_rgb_TDATA_WIDTH / RGB_PIX_W;
   localparam int R = PIX_PER_GRAY_BEAT / P;
   localparam int SW = (R > 1) ? $clog2(R) : 1;
   localparam int PW = GRAY_PIX_W * P;
   if ((C_M_AXIS_rgb_TDATA_WIDTH != 24 && C_M_AXIS_rgb_TDATA_WIDTH != 48 &&
        C_M_AXIS_rgb_TDATA_WIDTH != 96) ||
       C_S_AXIS_gray_TDATA_WIDTH != GRAY_PIX_W * PIX_PER_GRAY_BEAT) begin : g_bad_width
      $error("gray_to_rgb_axis: unsupported TDATA width");
   end
   logic [C_S_AXIS_gray_TDATA_WIDTH-1:0] hold_data;
   logic hold_user;
   logic hold_last;
   logic hold_valid;
   logic [SW-1:0] sub;
   logic last_sub;
   logic s_fire;
   logic m_fire;
   logic [PW-1:0] px;
   assign last_sub = (sub == SW'(R - 1));
   // Ready looks straight through to downstream ready so a new beat lands with no bubble.
   assign s_axis_gray.tready = !hold_valid || (m_axis_rgb.tready && last_sub);
   assign s_fire = s_axis_gray.tvalid && s_axis_gray.tready;
   assign m_fire = hold_valid && m_axis_rgb.tready;
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         hold_data <= '0;
         hold_user <= 1'b0;
         hold_last <= 1'b0;
         hold_valid <= 1'b0;
         sub <= '0;
      end else if (s_fire) begin
         hold_data <= s_axis_gray.tdata;
         hold_user <= s_axis_gray.tuser;
         hold_last <= s_axis_gray.tlast;
         hold_valid <= 1'b1;
         sub <= '0;
      end else if (m_fire) begin
         sub <= last_sub ? '0 : sub + 1'b1;
         hold_valid <= !last_sub;
      end
   end
   always_comb begin
      px = PW'(hold_data >> (PW * int'(sub)));
      m_axis_rgb.tdata = '0;
      for (int j = 0; j < P; j++)
         m_axis_rgb.tdata[RGB_PIX_W*j +: RGB_PIX_W] = gray8_to_rgb24(px[GRAY_PIX_W*j +: GRAY_PIX_W]);
   end
   assign m_axis_rgb.tvalid = hold_valid;
   assign m_axis_rgb.tuser = hold_user && (sub == '0);
   assign m_axis_rgb.tlast = hold_last && last_sub;
endmodule

// File: tb/tb_gray_to_rgb_axis.sv
// tb_gray_to_rgb_axis: scoreboard bench for the R=4 (24-bit) and R=1 (96-bit) configurations.
module tb_gray_to_rgb_axis;
   typedef struct {
      logic [23:0] data;
      logic user;
      logic last;
   } e4_t;
   logic clk = 0;
   logic rst_n = 0;
   int checks = 0;
   int failures = 0;
   e4_t q4[$];
   logic [97:0] q1[$];
   gray_to_rgb_axis_if #(32) s4();
   gray_to_rgb_axis_if #(24) m4();
   gray_to_rgb_axis_if #(32) s1();
   gray_to_rgb_axis_if #(96) m1();
   gray_to_rgb_axis #(.C_S_AXIS_gray_TDATA_WIDTH(32), .C_M_AXIS_rgb_TDATA_WIDTH(24)) d4 (
      .aclk(clk), .aresetn(rst_n), .s_axis_gray(s4), .m_axis_rgb(m4));
   gray_to_rgb_axis #(.C_S_AXIS_gray_TDATA_WIDTH(32), .C_M_AXIS_rgb_TDATA_WIDTH(96)) d1 (
      .aclk(clk), .aresetn(rst_n), .s_axis_gray(s1), .m_axis_rgb(m1));
   always #5 clk = ~clk;
   task automatic step4(input bit v, input logic [31:0] d, input bit u, input bit l, input bit rdy,
                        output bit took, output bit popped);
      e4_t e;
      logic [31:0] w;
      @(negedge clk);
      s4.tvalid = v; s4.tdata = d; s4.tuser = u; s4.tlast = l; m4.tready = rdy;
      #1;
      popped = m4.tvalid && m4.tready;
      if (popped) begin
         checks++;
         if (q4.size() == 0) begin
            failures++;
            $display("FAIL r4_extra_beat got=%h", m4.tdata);
         end else begin
            e = q4.pop_front();
            if ({m4.tdata, m4.tuser, m4.tlast} !== {e.data, e.user, e.last}) begin
               failures++;
               $display("FAIL r4_beat got=%h/%b/%b exp=%h/%b/%b", m4.tdata, m4.tuser, m4.tlast,
                        e.data, e.user, e.last);
            end
         end
      end
      took = v && s4.tready;
      if (took) begin
         w = d;
         for (int k = 0; k < 4; k++) begin
            e.data = {3{w[8*k +: 8]}};
            e.user = u && k == 0;
            e.last = l && k == 3;
            q4.push_back(e);
         end
      end
   endtask
   task automatic step1(input bit v, input logic [31:0] d, input bit rdy, output bit took, output bit popped);
      logic [97:0] e;
      logic [31:0] w;
      @(negedge clk);
      s1.tvalid = v; s1.tdata = d; s1.tuser = 1'b0; s1.tlast = 1'b0; m1.tready = rdy;
      #1;
      popped = m1.tvalid && m1.tready;
      if (popped) begin
         checks++;
         if (q1.size() == 0) begin
            failures++;
            $display("FAIL r1_extra_beat got=%h", m1.tdata);
         end else begin
            e = q1.pop_front();
            if ({m1.tdata, m1.tuser, m1.tlast} !== e) begin
               failures++;
               $display("FAIL r1_beat got=%h exp=%h", {m1.tdata, m1.tuser, m1.tlast}, e);
            end
         end
      end
      took = v && s1.tready;
      if (took) begin
         w = d;
         e = '0;
         for (int j = 0; j < 4; j++) e[2 + 24*j +: 24] = {3{w[8*j +: 8]}};
         q1.push_back(e);
      end
   endtask
   task automatic drain4(input string name);
      bit t, p;
      for (int i = 0; i < 20 && q4.size() != 0; i++) step4(0, 0, 0, 0, 1, t, p);
      step4(0, 0, 0, 0, 1, t, p);
      checks++;
      if (q4.size() != 0 || m4.tvalid !== 1'b0) begin
         failures++;
         $display("FAIL %s_drain left=%0d valid=%b exp=0/0", name, q4.size(), m4.tvalid);
      end
   endtask
   task automatic test_reset();
      rst_n = 0;
      #1;
      checks++;
      if ({m4.tvalid, m4.tdata, m4.tuser, m4.tlast, s4.tready} !== {1'b0, 24'h0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_r4 got=%b/%h/%b/%b/%b exp=0/0/0/0/1", m4.tvalid, m4.tdata, m4.tuser, m4.tlast, s4.tready);
      end
      checks++;
      if ({m1.tvalid, m1.tdata, m1.tuser, m1.tlast, s1.tready} !== {1'b0, 96'h0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_r1 got=%b/%h/%b/%b/%b exp=0/0/0/0/1", m1.tvalid, m1.tdata, m1.tuser, m1.tlast, s1.tready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask
   task automatic test_expand();
      bit t, p;
      step4(1, 32'h44332211, 1, 0, 1, t, p);
      checks++;
      if (t !== 1'b1) begin failures++; $display("FAIL expand_accept got=%b exp=1", t); end
      for (int k = 0; k < 4; k++) begin
         step4(0, 0, 0, 0, 1, t, p);
         checks++;
         if (s4.tready !== (k == 3)) begin
            failures++;
            $display("FAIL expand_s_ready sub=%0d got=%b exp=%b", k, s4.tready, k == 3);
         end
         checks++;
         if (p !== 1'b1) begin failures++; $display("FAIL expand_stream sub=%0d got=%b exp=1", k, p); end
      end
      drain4("expand");
   endtask
   task automatic test_tlast();
      bit t, p;
      step4(1, 32'hDDCCBBAA, 0, 1, 1, t, p);
      for (int k = 0; k < 4; k++) begin
         step4(0, 0, 0, 0, 1, t, p);
         checks++;
         if ({m4.tuser, m4.tlast} !== {1'b0, k == 3}) begin
            failures++;
            $display("FAIL tlast_flags sub=%0d got=%b%b exp=0%b", k, m4.tuser, m4.tlast, k == 3);
         end
      end
      drain4("tlast");
   endtask
   task automatic test_backpressure();
      bit t, p;
      step4(1, 32'h44332211, 1, 1, 1, t, p);
      step4(0, 0, 0, 0, 1, t, p);
      for (int i = 0; i < 3; i++) begin
         step4(0, 0, 0, 0, 0, t, p);
         checks++;
         if ({m4.tvalid, m4.tdata, m4.tuser, m4.tlast, s4.tready} !== {1'b1, 24'h222222, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got=%b/%h/%b/%b/%b exp=1/222222/0/0/0", i, m4.tvalid,
                     m4.tdata, m4.tuser, m4.tlast, s4.tready);
         end
      end
      step4(0, 0, 0, 0, 1, t, p);
      step4(0, 0, 0, 0, 1, t, p);
      checks++;
      if (m4.tdata !== 24'h333333) begin failures++; $display("FAIL stall_resume got=%h exp=333333", m4.tdata); end
      drain4("stall");
   endtask
   task automatic test_back_to_back();
      bit t, p;
      logic [31:0] words[2] = '{32'h0F0E0D0C, 32'hA5B6C7D8};
      int idx = 0;
      int beats = 0;
      for (int c = 0; c < 9; c++) begin
         step4(idx < 2, idx < 2 ? words[idx] : 32'h0, c == 0, idx == 1, 1, t, p);
         if (c == 4) begin
            checks++;
            if (s4.tready !== 1'b1) begin failures++; $display("FAIL b2b_ready_sub3 got=%b exp=1", s4.tready); end
         end
         if (t) idx++;
         if (p) beats++;
      end
      checks++;
      if (beats != 8 || idx != 2) begin
         failures++;
         $display("FAIL b2b_throughput beats=%0d inputs=%0d exp=8/2", beats, idx);
      end
      drain4("b2b");
   endtask
   task automatic test_r1();
      bit t, p;
      logic [31:0] w;
      int ins = 0;
      int outs = 0;
      for (int c = 0; c < 7; c++) begin
         w = (c == 0) ? 32'h04030201 : $urandom;
         step1(c < 6, w, 1, t, p);
         if (c == 1) begin
            checks++;
            if (m1.tdata !== 96'h040404_030303_020202_010101) begin
               failures++;
               $display("FAIL r1_first got=%h exp=040404030303020202010101", m1.tdata);
            end
         end
         if (t) ins++;
         if (p) outs++;
      end
      step1(0, 0, 1, t, p);
      checks++;
      if (ins != 6 || outs != 6 || q1.size() != 0) begin
         failures++;
         $display("FAIL r1_rate in=%0d out=%0d left=%0d exp=6/6/0", ins, outs, q1.size());
      end
   endtask
   task automatic test_reset_mid();
      bit t, p;
      step4(1, 32'h12345678, 0, 0, 1, t, p);
      step4(0, 0, 0, 0, 1, t, p);
      step4(0, 0, 0, 0, 1, t, p);
      @(negedge clk);
      rst_n = 0;
      #1;
      checks++;
      if ({m4.tvalid, m4.tdata} !== {1'b0, 24'h0}) begin
         failures++;
         $display("FAIL reset_mid got=%b/%h exp=0/000000", m4.tvalid, m4.tdata);
      end
      q4.delete();
      @(negedge clk);
      rst_n = 1;
      step4(1, 32'h88776655, 0, 0, 1, t, p);
      step4(0, 0, 0, 0, 1, t, p);
      checks++;
      if ({m4.tvalid, m4.tdata} !== {1'b1, 24'h555555}) begin
         failures++;
         $display("FAIL reset_restart got=%b/%h exp=1/555555", m4.tvalid, m4.tdata);
      end
      drain4("restart");
   endtask
   initial begin
      s4.tvalid = 0; s4.tdata = 0; s4.tuser = 0; s4.tlast = 0; m4.tready = 0;
      s1.tvalid = 0; s1.tdata = 0; s1.tuser = 0; s1.tlast = 0; m1.tready = 0;
      test_reset();
      test_expand();
      test_tlast();
      test_backpressure();
      test_back_to_back();
      test_r1();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gray_to_rgb_axis.md
# gray_to_rgb_axis

Expands a packed 8-bit grayscale AXI4-Stream (4 pixels per beat) into a 24-bit-per-pixel RGB AXI4-Stream with R=G=B=gray. It also downsizes each input beat into 1, 2 or 4 output beats. It is the inverse-direction companion of the stereovision RGB→gray stage and sits between the gray/disparity pipeline output and the RGB video-out/VDMA path. It holds one input beat and serialises it under full AXIS backpressure.

## Interface
Parameters:
- C_S_AXIS_gray_TDATA_WIDTH, 32, input width; fixed at 4 pixels × 8 bit.
- C_M_AXIS_rgb_TDATA_WIDTH, 24, output width; legal values 24, 48, 96 (1, 2, 4 pixels per beat). Any other value is an elaboration error.

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_gray_tvalid  in  1  input beat valid.
- s_axis_gray_tready  out  1  input beat accepted when tvalid && tready.
- s_axis_gray_tdata  in  32  pixel i = bits [8i+7:8i], pixel 0 earliest on screen.
- s_axis_gray_tuser  in  1  start of frame.
- s_axis_gray_tlast  in  1  end of line.
- m_axis_rgb_tvalid  out  1  output beat valid.
- m_axis_rgb_tready  in  1  downstream ready.
- m_axis_rgb_tdata  out  C_M_AXIS_rgb_TDATA_WIDTH  output pixel j = bits [24j+23:24j] = {g,g,g}.
- m_axis_rgb_tuser  out  1  start of frame.
- m_axis_rgb_tlast  out  1  end of line.

## Operation
- Let P = C_M_AXIS_rgb_TDATA_WIDTH/24 and R = 4/P (R ∈ {4,2,1}).
- State: hold register (data, user, last), hold_valid flag, and sub-beat counter sub ∈ [0, R-1].
- Output beat k of a held input carries input pixels kP … kP+P-1, in ascending order in the output word.
- tuser: asserted only on sub-beat 0 of a held beat whose input tuser=1.
- tlast: asserted only on sub-beat R-1 of a held beat whose input tlast=1.
- m_axis_rgb_tvalid = hold_valid. m tdata/tuser/tlast are a mux of hold register and sub only, with no combinational path from s_* inputs.
- On an output handshake, sub increments. At sub=R-1, sub returns to 0 and hold_valid clears unless a new input is accepted in the same cycle.
- s_axis_gray_tready = !hold_valid || (m_axis_rgb_tready && sub==R-1). This is a deliberate combinational m→s ready path.
- Simultaneous last-sub-beat consumption and input acceptance: the hold register loads the new beat, hold_valid stays 1, sub=0. There is no bubble.
- AXIS stability: while m tvalid=1 and m tready=0, tdata/tuser/tlast hold constant.
- No internal checking of frame or line geometry; tuser/tlast pass through as described.

## Timing
- Reset (async assert, sync-to-aclk deassert handled upstream): hold_valid=0, sub=0, hold data=0, user=0, last=0. Consequently m_axis_rgb_tvalid=0, tdata=0, tuser=0, tlast=0, and s_axis_gray_tready=1.
- Latency: input accepted at edge n → first output beat valid in cycle after edge n (1 cycle).
- Throughput: one output beat per cycle when m tready=1 continuously. The input accepts one beat per R cycles; with R=1, one beat per cycle.
- Reset mid-beat: the held beat is discarded; the next accepted input starts at pixel 0.

## Structure
- Shared package stereo_axis_pkg holds:
  - constants GRAY_PIX_W=8, RGB_PIX_W=24, PIX_PER_GRAY_BEAT=4;
  - function gray8_to_rgb24 (replication).
- No sub-module. Hold register, counter and output mux are inline in one always_ff plus one always_comb.

## Test plan
- R=4, input 0x44332211, tuser=1, tlast=0, m tready=1 → outputs 0x111111 (tuser=1), 0x222222, 0x333333, 0x444444 on 4 consecutive cycles. s tready=0 during the first 3.
- R=4, input 0xDDCCBBAA, tlast=1 → tlast=1 only on the 0xDDDDDD beat; tuser=0 on all four beats.
- R=4, m tready low for 3 cycles while 0x222222 is presented → 0x222222 and flags held stable, then 0x333333 follows with no loss or duplication.
- R=4, two back-to-back inputs, m tready=1 → 8 output beats in 8 consecutive cycles. s tready=1 in the cycle of sub-beat 3.
- R=1 (96-bit), input 0x04030201 → single beat 0x040404_030303_020202_010101. Sustained one beat in and one beat out per cycle.
- R=4, assert aresetn low after 2 sub-beats → tvalid=0 immediately and tdata=0. After release, input 0x88776655 → first output 0x555555.
